otbn_pq_twiddle_unit: RTL and testbench

Multicycle twiddle-factor update unit for the OTBN-PQ NTT datapath. It sits directly upstream of the PQ ALU's twiddle input. On the decoder's `update_twiddle`, `update_omega`, `invert_twiddle` and `set_twiddle_as_psi` requests, it computes the next twiddle or omega value. Multiplications use a Montgomery multiplier (R = 2^LOG_R) with a registered Mul/Red/Corr pipeline; the ISPR block writes the result back into the twiddle or omega register.

---
 rtl/otbn_pq_twiddle_unit.sv | 125 ++++++++++++
 tb/tb_otbn_pq_twiddle_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/otbn_pq_twiddle_unit.sv
// Twiddle/omega update unit for the OTBN-PQ NTT datapath: Montgomery multiply
// (Mul/Red/Corr) plus single-cycle invert and set-to-psi operations.
module otbn_pq_twiddle_unit #(
  parameter int unsigned PQLEN = 32,
  parameter int unsigned LOG_R = 32  // must equal PQLEN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [1:0]       op_i,
  input  logic [PQLEN-1:0] twiddle_i,
  input  logic [PQLEN-1:0] omega_i,
  input  logic [PQLEN-1:0] psi_i,
  input  logic [PQLEN-1:0] prime_i,
  input  logic [LOG_R-1:0] prime_dash_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [PQLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    OpTwMulOmega = 2'b00,
    OpOmegaSq    = 2'b01,
    OpTwInvert   = 2'b10,
    OpTwSetPsi   = 2'b11
  } op_e;

  typedef enum logic [1:0] {StIdle, StMul, StRed, StCorr} state_e;

  state_e state_q, state_d;
  op_e    op;
  logic   accept;

  logic [2*PQLEN-1:0] t_q, prod_d;
  logic [PQLEN-1:0]   q_q;
  logic [LOG_R-1:0]   pd_q;
  logic [PQLEN:0]     u_q, u_d;
  logic [PQLEN-1:0]   mul_a;
  logic [LOG_R-1:0]   m;
  logic [2*PQLEN:0]   mq, s;
  logic [PQLEN:0]     q_ext, u_red;

  logic             ready_q, done_q, done_d, result_we;
  logic [PQLEN-1:0] result_q, result_d;

  assign op     = op_e'(op_i);
  assign accept = (state_q == StIdle) && req_i;

  // The product is formed at acceptance so done lands in the Corr cycle.
  assign mul_a  = (op == OpOmegaSq) ? omega_i : twiddle_i;
  assign prod_d = {{PQLEN{1'b0}}, mul_a} * {{PQLEN{1'b0}}, omega_i};

  // Montgomery reduction: low LOG_R bits of t + m*q are zero by construction.
  assign m     = t_q[LOG_R-1:0] * pd_q;
  assign mq    = {{(PQLEN + 1){1'b0}}, m} * {{(PQLEN + 1){1'b0}}, q_q};
  assign s     = {1'b0, t_q} + mq;
  assign u_d   = (PQLEN + 1)'(s >> LOG_R);
  assign q_ext = {1'b0, q_q};
  assign u_red = (u_q >= q_ext) ? (u_q - q_ext) : u_q;

  always_comb begin
    state_d   = state_q;
    result_d  = '0;
    result_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (op)
            OpTwMulOmega, OpOmegaSq: state_d = StMul;
            OpTwInvert: begin
              result_d  = (twiddle_i == '0) ? '0 : prime_i - twiddle_i;
              result_we = 1'b1;
            end
            OpTwSetPsi: begin
              result_d  = psi_i;
              result_we = 1'b1;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StMul: state_d = StRed;
      StRed: begin
        state_d   = StCorr;
        result_d  = PQLEN'(u_red);
        result_we = 1'b1;
      end
      StCorr:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    done_d = result_we;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      t_q  <= prod_d;
      q_q  <= prime_i;
      pd_q <= prime_dash_i;
    end
    if (state_q == StMul) begin
      u_q <= u_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StIdle);
      done_q  <= done_d;
      if (result_we) begin
        result_q <= result_d;
      end
    end
  end

  assign ready_o  = ready_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_otbn_pq_twiddle_unit.sv
// Scoreboard bench for otbn_pq_twiddle_unit: expected result and completion cycle
// are queued at acceptance and checked whenever done_o pulses.
module tb_otbn_pq_twiddle_unit;

  localparam int unsigned PQLEN = 32;
  localparam int unsigned LOG_R = 32;
  localparam logic [31:0] Q     = 32'd3329;
  localparam logic [31:0] QDASH = 32'h94570CFF;
  localparam logic [1:0] OpMul = 2'b00, OpSq = 2'b01, OpInv = 2'b10, OpPsi = 2'b11;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             req_i = 1'b0;
  logic [1:0]       op_i = 2'b00;
  logic [PQLEN-1:0] twiddle_i = '0, omega_i = '0, psi_i = '0;
  logic [PQLEN-1:0] prime_i = Q;
  logic [LOG_R-1:0] prime_dash_i = QDASH;
  logic             ready_o, done_o;
  logic [PQLEN-1:0] result_o;

  otbn_pq_twiddle_unit #(.PQLEN(PQLEN), .LOG_R(LOG_R)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .op_i        (op_i),
    .twiddle_i   (twiddle_i),
    .omega_i     (omega_i),
    .psi_i       (psi_i),
    .prime_i     (prime_i),
    .prime_dash_i(prime_dash_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  longint rinv = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (done_o) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {32'd0, result_o}, {32'd0, e.res});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  function automatic logic [31:0] mont(input longint a, input longint b);
    return 32'((((a * b) % longint'(Q)) * rinv) % longint'(Q));
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] tw, input logic [31:0] om,
                       input logic [31:0] ps, input logic [31:0] exp, input int lat,
                       input bit push);
    @(negedge clk_i);
    op_i = op; twiddle_i = tw; omega_i = om; psi_i = ps; req_i = 1'b1;
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    if (push) sb.push_back('{exp, cyc + lat - 1});
  endtask

  task automatic check_busy();
    repeat (3) begin
      @(negedge clk_i);
      check("ready_busy", {63'd0, ready_o}, 64'd0);
    end
    @(negedge clk_i);
    check("ready_after", {63'd0, ready_o}, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk_i);
      #1;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int acc;
    logic [31:0] a, b;

    for (longint x = 1; x < longint'(Q); x++) begin
      if ((x * 1353) % longint'(Q) == 1) rinv = x;
    end

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", {63'd0, ready_o}, 64'd1);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_result", {32'd0, result_o}, 64'd0);

    // Identity and upper-bound Montgomery products
    issue(OpMul, 32'd1234, 32'd1353, 32'd0, 32'd1234, 3, 1'b1);
    check_busy();
    drain();
    issue(OpMul, 32'd3328, 32'd1353, 32'd0, 32'd3328, 3, 1'b1);
    check_busy();
    drain();
    issue(OpSq, 32'd999, 32'd0, 32'd0, 32'd0, 3, 1'b1);
    drain();
    issue(OpSq, 32'd0, 32'd1353, 32'd0, 32'd1353, 3, 1'b1);
    drain();

    for (int i = 0; i < 6; i++) begin
      a = 32'($urandom_range(0, 3328));
      b = 32'($urandom_range(0, 3328));
      if (i % 2 == 0) issue(OpMul, a, b, 32'd0, mont(longint'(a), longint'(b)), 3, 1'b1);
      else            issue(OpSq, a, b, 32'd0, mont(longint'(b), longint'(b)), 3, 1'b1);
      drain();
    end

    // Invert and back-to-back set-psi
    issue(OpInv, 32'd1, 32'd0, 32'd0, 32'd3328, 1, 1'b1);
    @(negedge clk_i);
    check("inv_ready", {63'd0, ready_o}, 64'd1);
    drain();
    issue(OpInv, 32'd0, 32'd0, 32'd0, 32'd0, 1, 1'b1);
    issue(OpPsi, 32'd5, 32'd0, 32'd17, 32'd17, 1, 1'b1);
    drain();

    // Request held while busy is dropped, then accepted once ready
    issue(OpMul, 32'd1234, 32'd1353, 32'd0, 32'd1234, 3, 1'b1);
    op_i = OpPsi; psi_i = 32'd17; req_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    req_i = 1'b0;
    sb.push_back('{32'd17, cyc});
    drain();

    // Reset in the middle of a multiply discards it
    issue(OpMul, 32'd100, 32'd1353, 32'd0, 32'd0, 3, 1'b0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_done", {63'd0, done_o}, 64'd0);
    check("midrst_result", {32'd0, result_o}, 64'd0);
    check("midrst_ready", {63'd0, ready_o}, 64'd1);
    repeat (3) @(negedge clk_i);
    issue(OpMul, 32'd1234, 32'd1353, 32'd0, 32'd1234, 3, 1'b1);
    drain();

    // Inputs changing after acceptance do not affect the result
    issue(OpMul, 32'd1234, 32'd1353, 32'd0, 32'd1234, 3, 1'b1);
    twiddle_i = '0; omega_i = '0; prime_i = '0; prime_dash_i = '0;
    drain();
    prime_i = Q; prime_dash_i = QDASH;

    repeat (4) @(negedge clk_i);
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
